asteroid_spawner: RTL and testbench
===================================

// Module: asteroid_spawner
// PURPOSE
//  Downstream consumer of the random asteroid placement stage (direction/X/Y/size).
//  Owns NUM_SLOTS asteroid object slots. When a slot is free and the spawn delay has
//  elapsed, it samples the current random placement and loads it into one slot.
//  The load is a one-cycle one-hot pulse plus a held payload.
//  Sits between the RNG placement stage and the per-asteroid motion/render modules.
// PARAMETERS
//  NUM_SLOTS    4   number of asteroid slots (2..8)
//  SPAWN_DELAY  60  frame ticks between spawn decision and load (0..255; 0 = no wait)
// PORTS
//  iClk         in   1   system clock; all state on rising edge
//  iRst         in   1   asynchronous, active-low reset
//  iFrameTick   in   1   one-cycle pulse, once per video frame
//  iEnable      in   1   game running; 0 suspends spawning
//  iDir         in   3   placement direction (updated on falling edge upstream)
//  iPosX        in   11  placement X
//  iPosY        in   11  placement Y
//  iSize        in   2   placement size
//  iSlotFree    in   NUM_SLOTS  bit k=1: slot k inactive, may be loaded
//  oLoad        out  NUM_SLOTS  one-hot load strobe, high exactly one cycle
//  oDir         out  3   latched direction, valid from oLoad onward, held
//  oPosX        out  11  latched X, held
//  oPosY        out  11  latched Y, held
//  oSize        out  2   latched size (remapped), held
//  oBusy        out  1   1 when FSM not in IDLE
//  oSpawnCount  out  8   total loads since reset, saturates at 255
// BEHAVIOUR
//  Reset (iRst=0, async): state=IDLE, delay counter=0, round-robin pointer=0.
//   All outputs 0. Reset asserted mid-spawn aborts the spawn; no oLoad is issued.
//  FSM states: IDLE, WAIT, SAMPLE, LOAD.
//   IDLE:   if iEnable && |iSlotFree: counter<=SPAWN_DELAY.
//           Go to WAIT, or straight to SAMPLE if SPAWN_DELAY==0.
//   WAIT:   if !iEnable -> IDLE (counter discarded).
//           Else on iFrameTick: counter<=counter-1; when the tick takes it 1->0 -> SAMPLE.
//           Non-tick cycles hold the counter.
//   SAMPLE: register iDir/iPosX/iPosY/iSize into the payload.
//           Choose slot: first free slot searching upward from pointer, wrapping
//           NUM_SLOTS-1 -> 0. If none free this cycle -> IDLE, payload not updated.
//           Else -> LOAD.
//   LOAD:   oLoad = one-hot of chosen slot for this cycle only.
//           pointer <= chosen+1 (mod NUM_SLOTS); oSpawnCount += 1 (saturating).
//           Next state IDLE.
//  Latency: after entering WAIT, SAMPLE occurs the cycle after the SPAWN_DELAY-th
//   iFrameTick; oLoad follows one cycle later. Minimum IDLE->oLoad is 2 cycles
//   when SPAWN_DELAY=0.
//  Size remap: iSize 2'b00 -> oSize 2'b11; all other values pass through unchanged.
//  Payload (oDir/oPosX/oPosY/oSize) changes only in SAMPLE; held at all other times.
//  iSlotFree is sampled only in IDLE (any-free check) and SAMPLE (selection).
//   A slot freed or taken during WAIT has no effect until SAMPLE.
//  iFrameTick during SAMPLE/LOAD is ignored.
//  iEnable drop during SAMPLE or LOAD does not abort; the load completes.
//  oBusy = (state != IDLE), registered with state.
// TESTING
//  1. Reset, SPAWN_DELAY=3, iEnable=1, iSlotFree=4'b1111, tick every 10 cycles
//     -> oLoad=4'b0001 one cycle after SAMPLE, which follows the 3rd tick; oSpawnCount=1.
//  2. Hold iDir=5, iPosX=135, iPosY=0, iSize=0 through SAMPLE
//     -> oDir=5, oPosX=135, oPosY=0, oSize=3, held until the next SAMPLE.
//  3. Four back-to-back spawns, all slots free -> oLoad sequence 0001, 0010, 0100, 1000,
//     then 0001. With iSlotFree=4'b0100 and pointer=0 -> oLoad=0100.
//  4. iSlotFree -> 0 during WAIT; SAMPLE sees none free -> return to IDLE, no oLoad,
//     payload unchanged.
//  5. iEnable -> 0 mid-WAIT -> IDLE next cycle, oBusy=0. Re-enable -> full SPAWN_DELAY
//     re-counted. iRst pulse in SAMPLE -> no oLoad, all outputs 0.
//  6. Force 260 spawns with SPAWN_DELAY=0 -> oSpawnCount saturates at 255.

Source files
------------

// File: rtl/asteroid_spawner.sv
// Asteroid spawner: waits SPAWN_DELAY frames, samples the random placement
// and loads it into the next free asteroid slot (round-robin).
module asteroid_spawner #(
    parameter int NUM_SLOTS   = 4,
    parameter int SPAWN_DELAY = 60
) (
    input  logic                 iClk,
    input  logic                 iRst,
    input  logic                 iFrameTick,
    input  logic                 iEnable,
    input  logic [2:0]           iDir,
    input  logic [10:0]          iPosX,
    input  logic [10:0]          iPosY,
    input  logic [1:0]           iSize,
    input  logic [NUM_SLOTS-1:0] iSlotFree,
    output logic [NUM_SLOTS-1:0] oLoad,
    output logic [2:0]           oDir,
    output logic [10:0]          oPosX,
    output logic [10:0]          oPosY,
    output logic [1:0]           oSize,
    output logic                 oBusy,
    output logic [7:0]           oSpawnCount
);

    localparam int PW = $clog2(NUM_SLOTS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_SAMPLE,
        S_LOAD
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [7:0]    r_cnt;
    logic [PW-1:0] r_ptr;
    logic [PW-1:0] r_sel;
    logic [PW-1:0] w_pick;
    logic          w_found;
    logic [PW:0]   w_idx;
    logic          w_start;

    assign w_start = iEnable && (|iSlotFree);

    // Scan from the highest offset down so the nearest free slot wins.
    always_comb begin
        w_found = 1'b0;
        w_pick  = r_ptr;
        w_idx   = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            w_idx = {1'b0, r_ptr} + (PW+1)'(i);
            if (w_idx >= (PW+1)'(NUM_SLOTS)) begin
                w_idx = w_idx - (PW+1)'(NUM_SLOTS);
            end
            if (iSlotFree[w_idx[PW-1:0]]) begin
                w_found = 1'b1;
                w_pick  = w_idx[PW-1:0];
            end
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    w_next = (SPAWN_DELAY == 0) ? S_SAMPLE : S_WAIT;
                end
            end
            S_WAIT: begin
                if (!iEnable) begin
                    w_next = S_IDLE;
                end else if (iFrameTick && r_cnt == 8'd1) begin
                    w_next = S_SAMPLE;
                end
            end
            S_SAMPLE: w_next = w_found ? S_LOAD : S_IDLE;
            S_LOAD:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_ptr       <= '0;
            r_sel       <= '0;
            oDir        <= '0;
            oPosX       <= '0;
            oPosY       <= '0;
            oSize       <= '0;
            oSpawnCount <= '0;
        end else begin
            r_state <= w_next;
            unique case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_cnt <= 8'(SPAWN_DELAY);
                    end
                end
                S_WAIT: begin
                    if (iEnable && iFrameTick) begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                S_SAMPLE: begin
                    if (w_found) begin
                        r_sel <= w_pick;
                        oDir  <= iDir;
                        oPosX <= iPosX;
                        oPosY <= iPosY;
                        oSize <= (iSize == 2'b00) ? 2'b11 : iSize;
                    end
                end
                S_LOAD: begin
                    r_ptr <= (r_sel == PW'(NUM_SLOTS - 1)) ? '0 : r_sel + PW'(1);
                    if (oSpawnCount != 8'hFF) begin
                        oSpawnCount <= oSpawnCount + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign oLoad = (r_state == S_LOAD) ? (NUM_SLOTS'(1) << r_sel) : '0;
    assign oBusy = (r_state != S_IDLE);

endmodule

// File: tb/tb_asteroid_spawner.sv
// Directed bench for asteroid_spawner: delayed spawn, payload, round-robin,
// no-free abort, enable/reset aborts and count saturation.
module tb_asteroid_spawner;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic        tick  = 1'b0;
    logic        en    = 1'b0;
    logic        enB   = 1'b0;
    logic [2:0]  dir   = '0;
    logic [10:0] px    = '0;
    logic [10:0] py    = '0;
    logic [1:0]  sz    = '0;
    logic [3:0]  free  = '0;
    logic [3:0]  freeB = '0;

    logic [3:0]  loadA, loadB;
    logic [2:0]  dirA, dirB;
    logic [10:0] pxA, pxB, pyA, pyB;
    logic [1:0]  szA, szB;
    logic        busyA, busyB;
    logic [7:0]  cntA, cntB;

    int total = 0;
    int bad   = 0;

    asteroid_spawner #(.NUM_SLOTS(4), .SPAWN_DELAY(3)) u_a (
        .iClk(clk), .iRst(rst_n), .iFrameTick(tick), .iEnable(en),
        .iDir(dir), .iPosX(px), .iPosY(py), .iSize(sz), .iSlotFree(free),
        .oLoad(loadA), .oDir(dirA), .oPosX(pxA), .oPosY(pyA), .oSize(szA),
        .oBusy(busyA), .oSpawnCount(cntA)
    );

    asteroid_spawner #(.NUM_SLOTS(4), .SPAWN_DELAY(0)) u_b (
        .iClk(clk), .iRst(rst_n), .iFrameTick(tick), .iEnable(enB),
        .iDir(dir), .iPosX(px), .iPosY(py), .iSize(sz), .iSlotFree(freeB),
        .oLoad(loadB), .oDir(dirB), .oPosX(pxB), .oPosY(pyB), .oSize(szB),
        .oBusy(busyB), .oSpawnCount(cntB)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_pay(input string tag, input int d, input int x,
                           input int y, input int s);
        chk({tag, "_dir"}, 32'(dirA), 32'(d));
        chk({tag, "_x"}, 32'(pxA), 32'(x));
        chk({tag, "_y"}, 32'(pyA), 32'(y));
        chk({tag, "_size"}, 32'(szA), 32'(s));
    endtask

    task automatic do_tick;
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
    endtask

    task automatic gap(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_loadB(input string tag, input int exp);
        int n;
        n = 0;
        @(negedge clk);
        while (loadB == 4'b0000 && n < 12) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(loadB), 32'(exp));
    endtask

    int seqB [8] = '{1, 2, 4, 8, 1, 2, 4, 8};

    initial begin
        #2 rst_n = 1'b0;
        #1;
        chk("rst_loadA", 32'(loadA), 0);
        chk("rst_busyA", 32'(busyA), 0);
        chk("rst_cntA", 32'(cntA), 0);
        chk_pay("rst_pay", 0, 0, 0, 0);
        chk("rst_loadB", 32'(loadB), 0);

        // Spawn with delay 3, tick every 10 cycles
        @(negedge clk);
        rst_n = 1'b1;
        en    = 1'b1;
        free  = 4'hF;
        dir   = 3'd5;
        px    = 11'd135;
        py    = 11'd0;
        sz    = 2'd0;
        @(negedge clk);
        chk("t1_wait_busy", 32'(busyA), 1);
        gap(9); do_tick;
        gap(9); do_tick;
        gap(9);
        chk("t1_pre_noload", 32'(loadA), 0);
        do_tick;
        chk("t1_sample_noload", 32'(loadA), 0);
        chk("t1_sample_busy", 32'(busyA), 1);
        @(negedge clk);
        chk("t1_load", 32'(loadA), 1);
        chk_pay("t2_pay", 5, 135, 0, 3);
        @(negedge clk);
        chk("t1_load_onecyc", 32'(loadA), 0);
        chk("t1_count", 32'(cntA), 1);
        chk("t1_idle", 32'(busyA), 0);
        dir = 3'd1;
        px  = 11'd7;
        py  = 11'd9;
        sz  = 2'd2;

        // Slots vanish during WAIT
        @(negedge clk);
        free = 4'h0;
        chk("t4_wait_busy", 32'(busyA), 1);
        gap(2);
        chk_pay("t2_hold", 5, 135, 0, 3);
        do_tick; do_tick; do_tick;
        chk("t4_sample_busy", 32'(busyA), 1);
        @(negedge clk);
        chk("t4_idle", 32'(busyA), 0);
        chk("t4_noload", 32'(loadA), 0);
        chk_pay("t4_pay", 5, 135, 0, 3);
        chk("t4_count", 32'(cntA), 1);

        // Enable drop mid-WAIT, then full recount
        free = 4'hF;
        @(negedge clk);
        chk("t5_wait_busy", 32'(busyA), 1);
        do_tick;
        gap(2);
        en = 1'b0;
        @(negedge clk);
        chk("t5_abort_idle", 32'(busyA), 0);
        en = 1'b1;
        @(negedge clk);
        do_tick; do_tick;
        @(negedge clk);
        chk("t5_recount1", 32'(loadA), 0);
        @(negedge clk);
        chk("t5_recount2", 32'(loadA), 0);
        chk("t5_recount_busy", 32'(busyA), 1);
        do_tick;
        @(negedge clk);
        chk("t3_rr_ptr1", 32'(loadA), 2);
        chk_pay("t5_pay", 1, 7, 9, 2);
        @(negedge clk);
        chk("t5_count2", 32'(cntA), 2);

        // Reset while in SAMPLE
        @(negedge clk);
        do_tick; do_tick; do_tick;
        chk("t5_rst_sample_busy", 32'(busyA), 1);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_load", 32'(loadA), 0);
        chk("t5_rst_busy", 32'(busyA), 0);
        chk("t5_rst_count", 32'(cntA), 0);
        chk_pay("t5_rst_pay", 0, 0, 0, 0);
        @(negedge clk);
        chk("t5_rst_noload", 32'(loadA), 0);
        en    = 1'b0;
        free  = 4'h0;
        rst_n = 1'b1;

        // Back-to-back spawns, zero delay
        @(negedge clk);
        enB   = 1'b1;
        freeB = 4'hF;
        for (int k = 0; k < 8; k++) begin
            wait_loadB($sformatf("t3_seq%0d", k), seqB[k]);
        end
        freeB = 4'b0100;
        @(negedge clk);
        chk("t3_countB8", 32'(cntB), 8);
        wait_loadB("t3_free0100", 4);
        @(negedge clk);
        chk("t3_countB9", 32'(cntB), 9);

        // Saturation
        freeB = 4'hF;
        gap(800);
        chk("t6_saturate", 32'(cntB), 255);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
